// File: rtl/player_board.sv
// Per-player battleship board: ship storage, opponent-shot legality check and
// resolution, outgoing attack register and a SETUP/PLAY/DEAD state machine.
module player_board #(
   parameter int unsigned CELLS  = 10,
   parameter int unsigned SHOT_W = 8
) (
   input  logic                         i_clk,
   input  logic                         i_clr,
   input  logic [CELLS-1:0]             i_ship_in,
   input  logic                         i_ship_ld,
   input  logic                         i_start,
   input  logic [CELLS-1:0]             i_opp_attack,
   input  logic                         i_opp_valid,
   input  logic [CELLS-1:0]             i_own_in,
   input  logic                         i_own_ld,
   output logic [CELLS-1:0]             o_own_attack,
   output logic [CELLS-1:0]             o_board,
   output logic [$clog2(CELLS+1)-1:0]   o_ships_left,
   output logic [SHOT_W-1:0]            o_shots,
   output logic                         o_hit,
   output logic                         o_miss,
   output logic                         o_reject,
   output logic                         o_ok,
   output logic                         o_alive,
   output logic [1:0]                   o_state
);

   localparam int unsigned CNT_W = $clog2(CELLS+1);

   typedef enum logic [1:0] {
      StSetup = 2'b00,
      StPlay  = 2'b01,
      StDead  = 2'b10
   } state_e;

   state_e              r_state, w_state_nxt;
   logic [CELLS-1:0]    r_board, w_board_nxt;
   logic [CELLS-1:0]    r_prev, w_prev_nxt;
   logic [CELLS-1:0]    r_own, w_own_nxt;
   logic [SHOT_W-1:0]   r_shots, w_shots_nxt;
   logic                r_hit, w_hit_nxt;
   logic                r_miss, w_miss_nxt;
   logic                r_reject, w_reject_nxt;
   logic                r_ok, w_ok_nxt;

   logic [CELLS-1:0]    w_new;
   logic [CELLS-1:0]    w_new_m1;
   logic                w_onehot;
   logic                w_grow;
   logic                w_legal;
   logic [CELLS-1:0]    w_board_after;
   logic [CNT_W-1:0]    w_cnt;

   // Shot legality: exactly one newly attacked cell and no previously attacked cell dropped.
   always_comb begin
      w_new         = i_opp_attack & ~r_prev;
      w_new_m1      = w_new - CELLS'(1);
      w_onehot      = (w_new != '0) && ((w_new & w_new_m1) == '0);
      w_grow        = ((r_prev & ~i_opp_attack) == '0);
      w_legal       = w_onehot && w_grow;
      w_board_after = r_board & ~w_new;
   end

   // State register and all board/attack/pulse registers.
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) begin
         r_state  <= StSetup;
         r_board  <= '0;
         r_prev   <= '0;
         r_own    <= '0;
         r_shots  <= '0;
         r_hit    <= 1'b0;
         r_miss   <= 1'b0;
         r_reject <= 1'b0;
         r_ok     <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_board  <= w_board_nxt;
         r_prev   <= w_prev_nxt;
         r_own    <= w_own_nxt;
         r_shots  <= w_shots_nxt;
         r_hit    <= w_hit_nxt;
         r_miss   <= w_miss_nxt;
         r_reject <= w_reject_nxt;
         r_ok     <= w_ok_nxt;
      end
   end

   // Next-state logic; pulses default low so they last exactly one cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_board_nxt  = r_board;
      w_prev_nxt   = r_prev;
      w_own_nxt    = r_own;
      w_shots_nxt  = r_shots;
      w_hit_nxt    = 1'b0;
      w_miss_nxt   = 1'b0;
      w_reject_nxt = 1'b0;
      w_ok_nxt     = r_ok;
      case (r_state)
         StSetup: begin
            // A load in the same cycle as start wins; start is checked against the held board.
            if (i_ship_ld) begin
               w_board_nxt = i_ship_in;
            end else if (i_start && (r_board != '0)) begin
               w_state_nxt = StPlay;
            end
         end
         StPlay: begin
            if (i_opp_valid) begin
               if (w_legal) begin
                  w_prev_nxt  = i_opp_attack;
                  w_board_nxt = w_board_after;
                  if (r_shots != {SHOT_W{1'b1}}) begin
                     w_shots_nxt = r_shots + SHOT_W'(1);
                  end
                  w_hit_nxt  = |(w_new & r_board);
                  w_miss_nxt = ~|(w_new & r_board);
                  w_ok_nxt   = 1'b1;
                  if (w_board_after == '0) begin
                     w_state_nxt = StDead;
                  end
               end else begin
                  w_reject_nxt = 1'b1;
                  w_ok_nxt     = 1'b0;
               end
            end
            if (i_own_ld) begin
               w_own_nxt = i_own_in;
            end
         end
         StDead: begin
            w_state_nxt = StDead;
         end
         // Unused code 2'b11 recovers to SETUP.
         default: begin
            w_state_nxt = StSetup;
         end
      endcase
   end

   // Surviving ship count from the registered board.
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < int'(CELLS); i++) begin
         w_cnt = w_cnt + CNT_W'(r_board[i]);
      end
   end

   assign o_own_attack = r_own;
   assign o_board      = r_board;
   assign o_ships_left = w_cnt;
   assign o_shots      = r_shots;
   assign o_hit        = r_hit;
   assign o_miss       = r_miss;
   assign o_reject     = r_reject;
   assign o_ok         = r_ok;
   assign o_alive      = (r_state != StDead);
   assign o_state      = r_state;

endmodule

// File: tb/tb_player_board.sv
// Scoreboard bench for player_board: a behavioural model pushes expected outputs
// per driven cycle, and they are popped and compared one cycle later.
module tb_player_board;

   localparam int unsigned CELLS  = 10;
   localparam int unsigned SHOT_W = 8;

   typedef struct packed {
      logic [1:0]        state;
      logic [CELLS-1:0]  board;
      logic [3:0]        ships;
      logic [SHOT_W-1:0] shots;
      logic              hit;
      logic              miss;
      logic              rej;
      logic              ok;
      logic              alive;
      logic [CELLS-1:0]  own;
   } exp_t;

   logic              i_clk;
   logic              i_clr;
   logic [CELLS-1:0]  i_ship_in;
   logic              i_ship_ld;
   logic              i_start;
   logic [CELLS-1:0]  i_opp_attack;
   logic              i_opp_valid;
   logic [CELLS-1:0]  i_own_in;
   logic              i_own_ld;
   logic [CELLS-1:0]  o_own_attack;
   logic [CELLS-1:0]  o_board;
   logic [3:0]        o_ships_left;
   logic [SHOT_W-1:0] o_shots;
   logic              o_hit;
   logic              o_miss;
   logic              o_reject;
   logic              o_ok;
   logic              o_alive;
   logic [1:0]        o_state;

   int n_checks;
   int n_errors;
   exp_t q_exp[$];

   // Reference model state
   int               m_state;
   logic [CELLS-1:0] m_board;
   logic [CELLS-1:0] m_prev;
   logic [CELLS-1:0] m_own;
   int               m_shots;
   logic             m_ok;
   logic             m_hit;
   logic             m_miss;
   logic             m_rej;

   player_board #(
      .CELLS  (CELLS),
      .SHOT_W (SHOT_W)
   ) u_dut (
      .i_clk        (i_clk),
      .i_clr        (i_clr),
      .i_ship_in    (i_ship_in),
      .i_ship_ld    (i_ship_ld),
      .i_start      (i_start),
      .i_opp_attack (i_opp_attack),
      .i_opp_valid  (i_opp_valid),
      .i_own_in     (i_own_in),
      .i_own_ld     (i_own_ld),
      .o_own_attack (o_own_attack),
      .o_board      (o_board),
      .o_ships_left (o_ships_left),
      .o_shots      (o_shots),
      .o_hit        (o_hit),
      .o_miss       (o_miss),
      .o_reject     (o_reject),
      .o_ok         (o_ok),
      .o_alive      (o_alive),
      .o_state      (o_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_board = '0;
      m_prev  = '0;
      m_own   = '0;
      m_shots = 0;
      m_ok    = 1'b1;
      m_hit   = 1'b0;
      m_miss  = 1'b0;
      m_rej   = 1'b0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.state = 2'(m_state);
      e.board = m_board;
      e.ships = 4'($countones(m_board));
      e.shots = SHOT_W'(m_shots);
      e.hit   = m_hit;
      e.miss  = m_miss;
      e.rej   = m_rej;
      e.ok    = m_ok;
      e.alive = (m_state != 2);
      e.own   = m_own;
      q_exp.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (q_exp.size() == 0) begin
         check_val({tag, ".queue"}, 32'd0, 32'd1);
         return;
      end
      e = q_exp.pop_front();
      check_val({tag, ".state"}, 32'(o_state), 32'(e.state));
      check_val({tag, ".board"}, 32'(o_board), 32'(e.board));
      check_val({tag, ".ships"}, 32'(o_ships_left), 32'(e.ships));
      check_val({tag, ".shots"}, 32'(o_shots), 32'(e.shots));
      check_val({tag, ".hit"}, 32'(o_hit), 32'(e.hit));
      check_val({tag, ".miss"}, 32'(o_miss), 32'(e.miss));
      check_val({tag, ".reject"}, 32'(o_reject), 32'(e.rej));
      check_val({tag, ".ok"}, 32'(o_ok), 32'(e.ok));
      check_val({tag, ".alive"}, 32'(o_alive), 32'(e.alive));
      check_val({tag, ".own"}, 32'(o_own_attack), 32'(e.own));
   endtask

   // Drive one cycle of stimulus, advance the model, then compare after the edge.
   task automatic step(input string tag, input logic [CELLS-1:0] ship, input logic sld,
                       input logic st, input logic [CELLS-1:0] opp, input logic ov,
                       input logic [CELLS-1:0] own, input logic old);
      logic [CELLS-1:0] nw;
      i_ship_in    = ship;
      i_ship_ld    = sld;
      i_start      = st;
      i_opp_attack = opp;
      i_opp_valid  = ov;
      i_own_in     = own;
      i_own_ld     = old;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      m_rej  = 1'b0;
      if (m_state == 0) begin
         if (sld) m_board = ship;
         else if (st && m_board != '0) m_state = 1;
      end else if (m_state == 1) begin
         if (ov) begin
            nw = opp & ~m_prev;
            if ($countones(nw) == 1 && (m_prev & ~opp) == '0) begin
               m_prev = opp;
               m_hit  = |(nw & m_board);
               m_miss = !m_hit;
               m_board = m_board & ~nw;
               if (m_shots < 255) m_shots++;
               m_ok = 1'b1;
               if (m_board == '0) m_state = 2;
            end else begin
               m_rej = 1'b1;
               m_ok  = 1'b0;
            end
         end
         if (old) m_own = own;
      end
      push_exp();
      @(posedge i_clk);
      #1;
      pop_cmp(tag);
   endtask

   task automatic idle_in();
      i_ship_in    = '0;
      i_ship_ld    = 1'b0;
      i_start      = 1'b0;
      i_opp_attack = '0;
      i_opp_valid  = 1'b0;
      i_own_in     = '0;
      i_own_ld     = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_in();
      i_clr = 1'b0;
      model_reset();
      #12;
      push_exp();
      pop_cmp("reset");
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;

      // Game 1: load, play, kill
      step("ld203",    10'h203, 1, 0, 10'h000, 0, 10'h000, 0);
      step("start",    10'h000, 0, 1, 10'h000, 0, 10'h000, 0);
      step("hit001",   10'h000, 0, 0, 10'h001, 1, 10'h000, 0);
      step("miss005",  10'h000, 0, 0, 10'h005, 1, 10'h000, 0);
      step("rej2new",  10'h000, 0, 0, 10'h01D, 1, 10'h000, 0);
      step("rejshrk",  10'h000, 0, 0, 10'h004, 1, 10'h000, 0);
      step("rej0new",  10'h000, 0, 0, 10'h005, 1, 10'h000, 0);
      step("hit+own",  10'h000, 0, 0, 10'h007, 1, 10'h010, 1);
      step("kill",     10'h000, 0, 0, 10'h207, 1, 10'h000, 0);
      step("deadign",  10'h3FF, 1, 1, 10'h3FF, 1, 10'h3FF, 1);
      step("deadidle", 10'h000, 0, 0, 10'h000, 0, 10'h000, 0);

      // Game 2: setup corner cases, then async clear mid-play
      i_clr = 1'b0;
      #1;
      model_reset();
      push_exp();
      pop_cmp("clr_dead");
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      step("start0",   10'h000, 0, 1, 10'h000, 0, 10'h000, 0);
      step("setupign", 10'h000, 0, 0, 10'h001, 1, 10'h0FF, 1);
      step("ld+start", 10'h005, 1, 1, 10'h000, 0, 10'h000, 0);
      step("start2",   10'h000, 0, 1, 10'h000, 0, 10'h000, 0);
      step("m010",     10'h000, 0, 0, 10'h010, 1, 10'h000, 0);
      step("m030",     10'h000, 0, 0, 10'h030, 1, 10'h000, 0);
      step("m070",     10'h000, 0, 0, 10'h070, 1, 10'h000, 0);
      #2;
      i_clr = 1'b0;
      #1;
      model_reset();
      push_exp();
      pop_cmp("clr_play");
      i_clr = 1'b1;
      idle_in();
      @(posedge i_clk);
      #1;
      step("postclr",  10'h000, 0, 1, 10'h000, 0, 10'h000, 0);

      check_val("queue_empty", 32'(q_exp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
